cook_sequencer: RTL and testbench
=================================

Name: cook_sequencer

Overview:
Central cooking controller for the microwave: sequences keypad digit entry into the countdown timer, gates the magnetron with a power-level duty cycle, and enforces the door interlock. Sits between the keypad encoder/button inputs and the timer, replacing the simple start/stop latch. Drives timer load/clear/enable and mag_on; takes timer zero status back.

Parameters:
MAX_DIGITS, 3, max digits accepted per entry (min, sec tens, sec ones)
DEFAULT_POWER, 10, power level after reset/clear (range 1..10)
DUTY_WINDOW, 10, duty-cycle window length in 1 Hz ticks
BEEP_SECS, 3, ticks the done beep stays asserted

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
tick_1hz  in  1  one-cycle pulse once per second
start_req  in  1  one-cycle start pulse (synchronized, debounced)
stop_req  in  1  one-cycle stop pulse
clear_req  in  1  one-cycle clear pulse
door_closed  in  1  level, 1 = door closed
key_valid  in  1  one-cycle pulse, key_digit valid
key_digit  in  4  digit 0..9
power_sel  in  1  one-cycle pulse: next digit sets power level
timer_zero  in  1  timer reads 0:00
timer_load  out  1  one-cycle pulse, shifts timer_data into timer
timer_data  out  4  digit for timer load
timer_clear  out  1  one-cycle pulse, clears timer to 0:00
timer_enable  out  1  timer counts down while high
mag_on  out  1  magnetron drive
beep  out  1  done indicator
power_level  out  4  current power level 1..10
state  out  3  IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4

Behaviour:
- Reset: state IDLE, power_level=DEFAULT_POWER, digit_cnt=0, duty_cnt=0, beep_cnt=0, pwr_pending=0; all pulse outputs, timer_enable, mag_on, beep = 0; timer_data=0.
- Event priority within one cycle: clear_req > door open > timer_zero > stop_req > start_req > key/power input.
- clear_req in any state: timer_clear pulse next cycle, state IDLE, power_level=DEFAULT_POWER, digit_cnt=0, pwr_pending=0.
- IDLE/ENTRY, key_valid with pwr_pending=0: if digit_cnt<MAX_DIGITS, timer_load=1 and timer_data=key_digit on next cycle, digit_cnt+1, state ENTRY; else digit ignored, no pulse.
- power_sel in IDLE/ENTRY sets pwr_pending; next key_valid sets power_level=key_digit (0 maps to 10), clears pwr_pending, no timer load. power_sel/keys ignored in COOK/PAUSE/DONE.
- ENTRY + start_req + door_closed + !timer_zero -> COOK; duty_cnt=0. Start with door open or timer_zero: ignored, state unchanged.
- COOK: timer_enable=1. duty_cnt increments on tick_1hz, wraps DUTY_WINDOW-1 -> 0. mag_on = (state==COOK) & door_closed & (duty_cnt < power_level); registered term ANDed combinationally with door_closed so door opening drops mag_on the same cycle.
- COOK + door open -> PAUSE; COOK + stop_req -> PAUSE; COOK + timer_zero -> DONE, mag_on and timer_enable 0 from that cycle, beep_cnt=0.
- PAUSE: timer_enable=0, mag_on=0, duty_cnt held. start_req + door_closed -> COOK (resume, duty_cnt kept). stop_req -> timer_clear pulse, IDLE, digit_cnt=0.
- DONE: beep=1; beep_cnt increments per tick; at BEEP_SECS ticks -> IDLE, beep=0. key_valid, stop_req or start_req in DONE -> IDLE immediately (event consumed). digit_cnt=0 on entry to IDLE.
- tick_1hz coincident with state change into COOK does not advance duty_cnt.
- Reset mid-COOK: mag_on drops asynchronously.

Test Plan:
- Reset, keys 1,3,0, door closed, start -> three timer_load pulses data 1,3,0; state COOK; mag_on=1 continuously at power 10.
- power_sel then digit 3, enter 0:25, start -> mag_on high for ticks 0..2, low for 3..9 of each 10-tick window.
- Open door mid-COOK -> mag_on 0 same cycle, state PAUSE; close + start -> COOK, duty_cnt continues from held value.
- Keys 1,2,3,4 -> exactly 3 load pulses; 4th ignored; start with door open -> stays ENTRY, mag_on=0.
- timer_zero in COOK -> DONE, beep high exactly BEEP_SECS=3 ticks, then IDLE.
- clear_req coincident with start_req in ENTRY -> timer_clear pulse, IDLE, power_level=10, mag_on never asserted.

Source files
------------

// File: rtl/cook_sequencer.sv
// cook_sequencer
//   Central cooking controller for the microwave. Shifts keypad digits into
//   the countdown timer, runs the cook/pause/done sequence, gates the
//   magnetron with a power-level duty cycle and enforces the door interlock.
//
// Ports
//   clock         system clock, all state on rising edge
//   resetn        asynchronous active-low reset
//   tick_1hz      one-cycle pulse once per second
//   start_req     one-cycle start pulse
//   stop_req      one-cycle stop pulse
//   clear_req     one-cycle clear pulse
//   door_closed   level, 1 = door closed
//   key_valid     one-cycle pulse, key_digit valid
//   key_digit     keypad digit 0..9
//   power_sel     one-cycle pulse, next digit sets the power level
//   timer_zero    timer reads 0:00
//   timer_load    one-cycle pulse, shifts timer_data into the timer
//   timer_data    digit for timer load
//   timer_clear   one-cycle pulse, clears the timer to 0:00
//   timer_enable  timer counts down while high
//   mag_on        magnetron drive
//   beep          done indicator
//   power_level   current power level 1..10
//   state         IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4
module cook_sequencer #(
    parameter int MAX_DIGITS    = 3,
    parameter int DEFAULT_POWER = 10,
    parameter int DUTY_WINDOW   = 10,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick_1hz,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       clear_req,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       power_sel,
    input  logic       timer_zero,
    output logic       timer_load,
    output logic [3:0] timer_data,
    output logic       timer_clear,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       beep,
    output logic [3:0] power_level,
    output logic [2:0] state
);

    localparam int DCW = $clog2(MAX_DIGITS + 1);
    localparam int TW  = (DUTY_WINDOW > 2) ? $clog2(DUTY_WINDOW) : 1;
    localparam int BW  = $clog2(BEEP_SECS + 1);

    localparam logic [DCW-1:0] DIGIT_LIMIT = DCW'(MAX_DIGITS);
    localparam logic [TW-1:0]  DUTY_LAST   = TW'(DUTY_WINDOW - 1);
    localparam logic [BW-1:0]  BEEP_LAST   = BW'(BEEP_SECS - 1);
    localparam logic [3:0]     POWER_INIT  = 4'(DEFAULT_POWER);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         cur_state, nxt_state;
    logic [DCW-1:0] digit_cnt, digit_nxt;
    logic [TW-1:0]  duty_cnt, duty_nxt;
    logic [BW-1:0]  beep_cnt, beep_nxt;
    logic [3:0]     power_q, power_nxt;
    logic           pend_q, pend_nxt;
    logic           load_nxt, clear_nxt;
    logic [3:0]     data_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur_state   <= IDLE;
            digit_cnt   <= '0;
            duty_cnt    <= '0;
            beep_cnt    <= '0;
            power_q     <= POWER_INIT;
            pend_q      <= 1'b0;
            timer_load  <= 1'b0;
            timer_clear <= 1'b0;
            timer_data  <= '0;
        end else begin
            cur_state   <= nxt_state;
            digit_cnt   <= digit_nxt;
            duty_cnt    <= duty_nxt;
            beep_cnt    <= beep_nxt;
            power_q     <= power_nxt;
            pend_q      <= pend_nxt;
            timer_load  <= load_nxt;
            timer_clear <= clear_nxt;
            timer_data  <= data_nxt;
        end
    end

    // Each state branch tests its events in priority order, so only the
    // highest-priority event present in a cycle takes effect.
    always_comb begin
        nxt_state = cur_state;
        digit_nxt = digit_cnt;
        duty_nxt  = duty_cnt;
        beep_nxt  = beep_cnt;
        power_nxt = power_q;
        pend_nxt  = pend_q;
        load_nxt  = 1'b0;
        clear_nxt = 1'b0;
        data_nxt  = timer_data;

        if (clear_req) begin
            nxt_state = IDLE;
            clear_nxt = 1'b1;
            power_nxt = POWER_INIT;
            digit_nxt = '0;
            pend_nxt  = 1'b0;
        end else begin
            unique case (cur_state)
                IDLE, ENTRY: begin
                    if (cur_state == ENTRY && start_req && door_closed && !timer_zero) begin
                        nxt_state = COOK;
                        duty_nxt  = '0;
                    end else begin
                        if (key_valid) begin
                            if (pend_q) begin
                                // Digit 0 on the keypad means full power.
                                power_nxt = (key_digit == 4'd0) ? 4'd10 : key_digit;
                                pend_nxt  = 1'b0;
                            end else if (digit_cnt < DIGIT_LIMIT) begin
                                load_nxt  = 1'b1;
                                data_nxt  = key_digit;
                                digit_nxt = digit_cnt + 1'b1;
                                nxt_state = ENTRY;
                            end
                        end
                        if (power_sel) begin
                            pend_nxt = 1'b1;
                        end
                    end
                end
                COOK: begin
                    if (!door_closed) begin
                        nxt_state = PAUSE;
                    end else if (timer_zero) begin
                        nxt_state = DONE;
                        beep_nxt  = '0;
                    end else if (stop_req) begin
                        nxt_state = PAUSE;
                    end else if (tick_1hz) begin
                        duty_nxt = (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop_req) begin
                        clear_nxt = 1'b1;
                        nxt_state = IDLE;
                        digit_nxt = '0;
                    end else if (start_req && door_closed) begin
                        nxt_state = COOK;
                    end
                end
                DONE: begin
                    if (key_valid || stop_req || start_req) begin
                        nxt_state = IDLE;
                        digit_nxt = '0;
                    end else if (tick_1hz) begin
                        if (beep_cnt == BEEP_LAST) begin
                            nxt_state = IDLE;
                            digit_nxt = '0;
                        end else begin
                            beep_nxt = beep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    digit_nxt = '0;
                end
            endcase
        end
    end

    // door_closed is applied combinationally so opening the door cuts the
    // magnetron in the same cycle rather than one clock later.
    assign mag_on       = (cur_state == COOK) && door_closed &&
                          (32'(duty_cnt) < 32'(power_q));
    assign timer_enable = (cur_state == COOK);
    assign beep         = (cur_state == DONE);
    assign power_level  = power_q;
    assign state        = cur_state;

endmodule

// File: tb/tb_cook_sequencer.sv
module tb_cook_sequencer;

    localparam int E_KEY   = 1;
    localparam int E_PS    = 2;
    localparam int E_START = 4;
    localparam int E_STOP  = 8;
    localparam int E_CLR   = 16;
    localparam int E_TICK  = 32;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_COOK  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       tick, start, stop, clr, door, kv, ps, tz;
    logic [3:0] kd;
    logic       timer_load, timer_clear, timer_enable, mag_on, beep;
    logic [3:0] timer_data, power_level;
    logic [2:0] state;

    cook_sequencer #(
        .MAX_DIGITS   (3),
        .DEFAULT_POWER(10),
        .DUTY_WINDOW  (10),
        .BEEP_SECS    (3)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tick_1hz    (tick),
        .start_req   (start),
        .stop_req    (stop),
        .clear_req   (clr),
        .door_closed (door),
        .key_valid   (kv),
        .key_digit   (kd),
        .power_sel   (ps),
        .timer_zero  (tz),
        .timer_load  (timer_load),
        .timer_data  (timer_data),
        .timer_clear (timer_clear),
        .timer_enable(timer_enable),
        .mag_on      (mag_on),
        .beep        (beep),
        .power_level (power_level),
        .state       (state)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: cook progress is an unbounded count of seconds
    // cooked since the last fresh start; the duty window is derived from it.
    int   ms, mdig, mpow, mpend, mticks, mbeep, mdata;
    logic mload, mclear;
    logic chk_en = 1'b0;

    task automatic model_reset;
        ms = S_IDLE; mdig = 0; mpow = 10; mpend = 0;
        mticks = 0; mbeep = 0; mdata = 0; mload = 1'b0; mclear = 1'b0;
    endtask

    task automatic model_step;
        mload  = 1'b0;
        mclear = 1'b0;
        if (clr) begin
            ms = S_IDLE; mclear = 1'b1; mpow = 10; mdig = 0; mpend = 0;
        end else if (ms == S_COOK) begin
            if (!door)      ms = S_PAUSE;
            else if (tz)    begin ms = S_DONE; mbeep = 0; end
            else if (stop)  ms = S_PAUSE;
            else if (tick)  mticks++;
        end else if (ms == S_PAUSE) begin
            if (stop) begin mclear = 1'b1; ms = S_IDLE; mdig = 0; end
            else if (start && door) ms = S_COOK;
        end else if (ms == S_DONE) begin
            if (kv || stop || start) begin ms = S_IDLE; mdig = 0; end
            else if (tick) begin
                mbeep++;
                if (mbeep == 3) begin ms = S_IDLE; mdig = 0; end
            end
        end else begin
            if (ms == S_ENTRY && start && door && !tz) begin
                ms = S_COOK; mticks = 0;
            end else begin
                if (kv) begin
                    if (mpend != 0) begin
                        mpow = (kd == 4'd0) ? 10 : int'(kd);
                        mpend = 0;
                    end else if (mdig < 3) begin
                        mload = 1'b1; mdata = int'(kd); mdig++; ms = S_ENTRY;
                    end
                end
                if (ps) mpend = 1;
            end
        end
    endtask

    // Compare process: every falling edge, DUT against model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("state",        32'(state),        ms);
            chk("timer_load",   32'(timer_load),   32'(mload));
            chk("timer_clear",  32'(timer_clear),  32'(mclear));
            chk("timer_data",   32'(timer_data),   mdata);
            chk("timer_enable", 32'(timer_enable), 32'(ms == S_COOK));
            chk("beep",         32'(beep),         32'(ms == S_DONE));
            chk("power_level",  32'(power_level),  mpow);
            chk("mag_on",       32'(mag_on),
                32'((ms == S_COOK) && door && ((mticks % 10) < mpow)));
        end
    end

    // Observation only: counts load pulses and magnetron-on cycles.
    int         load_cnt = 0;
    int         mag_cnt  = 0;
    logic [3:0] loads[$];
    always @(negedge clock) begin
        if (timer_load === 1'b1) begin
            load_cnt++;
            loads.push_back(timer_data);
        end
        if (mag_on === 1'b1) mag_cnt++;
    end

    task automatic cyc(input int ev, input int d);
        @(negedge clock);
        #1;
        kv    = (ev & E_KEY)   != 0;
        ps    = (ev & E_PS)    != 0;
        start = (ev & E_START) != 0;
        stop  = (ev & E_STOP)  != 0;
        clr   = (ev & E_CLR)   != 0;
        tick  = (ev & E_TICK)  != 0;
        kd    = 4'(d);
        @(posedge clock);
        if (resetn) model_step();
        else        model_reset();
        #1;
    endtask

    task automatic key(input int d);
        cyc(E_KEY, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int b, m, n;
        logic [9:0] pat;
        pat = 10'b0000000111;

        model_reset();
        resetn = 1'b0; door = 1'b1; tz = 1'b0;
        tick = 0; start = 0; stop = 0; clr = 0; kv = 0; ps = 0; kd = '0;
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", 32'(state),       0);
        chk("rst_power", 32'(power_level), 10);
        chk("rst_mag",   32'(mag_on),      0);
        chk("rst_data",  32'(timer_data),  0);
        resetn = 1'b1;

        // 1: keys 1,3,0 then start at full power
        b = load_cnt;
        key(1); key(3); key(0); cyc(0, 0);
        chk("t1_load_count", load_cnt - b, 3);
        chk("t1_data0", 32'(loads[b]),   1);
        chk("t1_data1", 32'(loads[b+1]), 3);
        chk("t1_data2", 32'(loads[b+2]), 0);
        cyc(E_START, 0);
        chk("t1_cook", 32'(state), 2);
        m = mag_cnt;
        for (int i = 0; i < 12; i++) begin cyc(E_TICK, 0); cyc(0, 0); end
        chk("t1_mag_continuous", mag_cnt - m, 24);
        cyc(E_STOP, 0);
        chk("t1_pause", 32'(state), 3);
        cyc(E_STOP, 0);
        chk("t1_stop_clear", 32'(timer_clear), 1);
        chk("t1_idle", 32'(state), 0);

        // 2: power 3, 0:25, duty pattern over two windows
        cyc(E_PS, 0); key(3);
        chk("t2_power", 32'(power_level), 3);
        key(0); key(2); key(5);
        cyc(E_START, 0);
        for (int i = 0; i < 20; i++) begin
            chk("t2_duty", 32'(mag_on), 32'(pat[i % 10]));
            cyc(E_TICK, 0);
        end
        cyc(E_CLR, 0);

        // 3: door open mid-cook, resume keeps duty position
        cyc(E_PS, 0); key(5);
        key(1); key(0); key(0);
        cyc(E_START, 0);
        cyc(E_TICK, 0); cyc(E_TICK, 0); cyc(E_TICK, 0);
        chk("t3_mag_before", 32'(mag_on), 1);
        door = 1'b0;
        #1;
        chk("t3_door_drop", 32'(mag_on), 0);
        chk("t3_still_cook", 32'(state), 2);
        cyc(0, 0);
        chk("t3_pause", 32'(state), 3);
        cyc(E_TICK, 0); cyc(E_TICK, 0);
        door = 1'b1;
        cyc(E_START, 0);
        chk("t3_resume", 32'(state), 2);
        chk("t3_duty3", 32'(mag_on), 1);
        cyc(E_TICK, 0);
        chk("t3_duty4", 32'(mag_on), 1);
        cyc(E_TICK, 0);
        chk("t3_duty5", 32'(mag_on), 0);
        cyc(E_CLR, 0);

        // 4: power digit 0 means 10; fourth digit ignored; start with door open
        cyc(E_PS, 0); key(4); cyc(E_PS, 0); key(0);
        chk("t4_power_zero", 32'(power_level), 10);
        b = load_cnt;
        key(1); key(2); key(3); key(4); cyc(0, 0);
        chk("t4_load_count", load_cnt - b, 3);
        door = 1'b0;
        cyc(E_START, 0);
        chk("t4_entry", 32'(state), 1);
        chk("t4_mag", 32'(mag_on), 0);
        door = 1'b1;
        cyc(E_CLR, 0);

        // 5: timer reaches zero, beep for three ticks; early exit by key
        key(0); key(0); key(5);
        cyc(E_START, 0);
        cyc(E_TICK, 0); cyc(E_TICK, 0);
        tz = 1'b1;
        cyc(0, 0);
        chk("t5_done", 32'(state), 4);
        chk("t5_beep", 32'(beep), 1);
        chk("t5_enable", 32'(timer_enable), 0);
        n = 0;
        while (beep === 1'b1 && n < 10) begin cyc(E_TICK, 0); cyc(0, 0); n++; end
        chk("t5_beep_ticks", n, 3);
        chk("t5_idle", 32'(state), 0);
        tz = 1'b0;
        key(0); key(0); key(3);
        cyc(E_START, 0);
        tz = 1'b1;
        cyc(0, 0);
        b = load_cnt;
        key(7); cyc(0, 0);
        chk("t5_key_exit", 32'(state), 0);
        chk("t5_key_no_load", load_cnt - b, 0);
        tz = 1'b0;

        // 6: clear beats start in ENTRY
        cyc(E_PS, 0); key(7);
        key(4); key(5);
        m = mag_cnt;
        cyc(E_CLR | E_START, 0);
        chk("t6_clear", 32'(timer_clear), 1);
        chk("t6_idle", 32'(state), 0);
        chk("t6_power", 32'(power_level), 10);
        cyc(0, 0);
        chk("t6_no_mag", mag_cnt - m, 0);

        // 7: asynchronous reset mid-cook
        key(1);
        cyc(E_START, 0);
        cyc(E_TICK, 0);
        chk("t7_mag_on", 32'(mag_on), 1);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("t7_mag_async", 32'(mag_on), 0);
        chk("t7_state_async", 32'(state), 0);
        cyc(0, 0);
        resetn = 1'b1;
        cyc(0, 0); cyc(0, 0);

        chk_en = 1'b0;
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
